// File: rtl/sddac_pkg.sv
// sddac_pkg: integrator widths, saturation and LFSR constants for
// sigma_delta_dac_nch (optional dither under SDDAC_DITHER_EN).
package sddac_pkg;

  localparam int ACC_W = 40;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic int i1_width(input int w);
    return w + 3;
  endfunction

  function automatic int i2_width(input int w);
    return w + 5;
  endfunction

  // Clamp a wide sum into a signed register of the given width.
  function automatic acc_t sat_to(input acc_t v, input int bits);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (bits - 1)) - acc_t'(1);
    lo = -hi - acc_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sigma_delta_dac_nch_channel.sv
// sddac_channel: one first/second-order modulator with its active
// sample register, saturating integrators and registered bit.
module sddac_channel
  import sddac_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ORDER = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] pend,
  input  logic [1:0]       dither,
  output logic             q
);

  localparam int W1 = i1_width(WIDTH);
  localparam int W2 = i2_width(WIDTH);
  localparam acc_t H = acc_t'(1) <<< (WIDTH - 1);
  localparam logic [WIDTH-1:0] MID =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]     active;
  logic signed [W1-1:0] i1;
  logic signed [W2-1:0] i2;

  acc_t xs;
  acc_t fb;
  acc_t i1_new;
  acc_t i2_new;
  logic q_new;

  always_comb begin
    xs     = acc_t'(active) - H
           + acc_t'($signed(dither));
    fb     = q ? H : -H;
    i1_new = sat_to(acc_t'(i1) + xs - fb, W1);
    i2_new = sat_to(acc_t'(i2) + i1_new - fb, W2);
    q_new  = (ORDER == 1) ? (i1_new >= 0)
                          : (i2_new >= 0);
  end

  // active is replaced after the step, so a tick uses the old sample
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i1     <= '0;
      i2     <= '0;
      q      <= 1'b0;
      active <= MID;
    end else begin
      if (tick) begin
        i1 <= i1_new[W1-1:0];
        i2 <= i2_new[W2-1:0];
        q  <= q_new;
      end
      if (load) active <= pend;
    end
  end

endmodule

// File: rtl/sigma_delta_dac_nch.sv
// sigma_delta_dac_nch: shared tick, pending buffer and handshake for
// CHANNELS modulators; SDDAC_DITHER_EN adds LFSR dither.
module sigma_delta_dac_nch
  import sddac_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int ORDER    = 1,
  parameter int CE_DIV   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      d_valid,
  output logic                      d_ready,
  output logic [CHANNELS-1:0]       q
);

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("sigma_delta_dac_nch: ORDER must be 1 or 2");
  end

  localparam logic [15:0] CNT_MAX = 16'(CE_DIV - 1);

  logic [15:0]               cnt;
  logic                      tick;
  logic                      pend_valid;
  logic                      xfer;
  logic                      load;
  logic [CHANNELS*WIDTH-1:0] pending;
  logic [2*CHANNELS-1:0]     dbits;

  assign tick    = (cnt == CNT_MAX);
  assign d_ready = !pend_valid;
  assign xfer    = d_valid && !pend_valid;
  assign load    = tick && pend_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      pend_valid <= 1'b0;
      pending    <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 16'd1;
      if (xfer) begin
        pending    <= d;
        pend_valid <= 1'b1;
      end else if (load) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef SDDAC_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (tick) begin
      lfsr <= {1'b0, lfsr[15:1]}
            ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
    end
  end

  assign dbits = lfsr[2*CHANNELS-1:0];
`else
  assign dbits = '0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0] dith;

    // two LFSR bits give a signed -1/0/+1 LSB offset
    assign dith = {1'b0, dbits[2*c]}
                - {1'b0, dbits[2*c+1]};

    sddac_channel #(
      .WIDTH (WIDTH),
      .ORDER (ORDER)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .load    (load),
      .pend    (pending[c*WIDTH +: WIDTH]),
      .dither  (dith),
      .q       (q[c])
    );
  end

endmodule

// File: tb/tb_sigma_delta_dac_nch.sv
// tb_sigma_delta_dac_nch: scoreboard bench for two instances
// (order 1 / CE_DIV 1 and order 2 / CE_DIV 4), 2 x 16-bit each.
module tb_sigma_delta_dac_nch;

  localparam int W  = 16;
  localparam int CH = 2;
  localparam longint H = 64'sd32768;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH*W-1:0] d_a   = '0;
  logic [CH*W-1:0] d_b   = '0;
  logic          dv_a    = 1'b0;
  logic          dv_b    = 1'b0;
  logic          rdy_a;
  logic          rdy_b;
  logic [CH-1:0] q_a;
  logic [CH-1:0] q_b;

  always #5 clk = ~clk;

  sigma_delta_dac_nch #(
    .WIDTH(W), .CHANNELS(CH), .ORDER(1), .CE_DIV(1)
  ) u_a (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d_a),
    .d_valid (dv_a),
    .d_ready (rdy_a),
    .q       (q_a)
  );

  sigma_delta_dac_nch #(
    .WIDTH(W), .CHANNELS(CH), .ORDER(2), .CE_DIV(4)
  ) u_b (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d_b),
    .d_valid (dv_b),
    .d_ready (rdy_b),
    .q       (q_b)
  );

  typedef struct {
    logic [CH-1:0] qa;
    logic [CH-1:0] qb;
    logic          ra;
    logic          rb;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  longint m_i1[2][CH];
  longint m_i2[2][CH];
  longint m_act[2][CH];
  longint m_pend[2][CH];
  logic   m_q[2][CH];
  logic   m_pv[2];
  logic   m_tk[2];
  int     m_cnt[2];
  int     ord[2]  = '{1, 2};
  int     cdiv[2] = '{1, 4};

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int bits);
    longint hi;
    longint lo;
    hi = (longint'(1) << (bits - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_step(input int k, input logic rst_n,
                            input logic [CH*W-1:0] din,
                            input logic dv);
    logic   tk;
    logic   pv0;
    longint xs;
    longint fb;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_i1[k][c]  = 0;
        m_i2[k][c]  = 0;
        m_q[k][c]   = 1'b0;
        m_act[k][c] = H;
      end
      m_pv[k]  = 1'b0;
      m_cnt[k] = 0;
      m_tk[k]  = 1'b0;
    end else begin
      tk  = (m_cnt[k] == cdiv[k] - 1);
      pv0 = m_pv[k];
      for (int c = 0; c < CH; c++) begin
        if (tk) begin
          xs = m_act[k][c] - H;
          fb = m_q[k][c] ? H : -H;
          m_i1[k][c] = sat(m_i1[k][c] + xs - fb, W + 3);
          m_i2[k][c] = sat(m_i2[k][c] + m_i1[k][c] - fb, W + 5);
          m_q[k][c]  = (ord[k] == 1) ? (m_i1[k][c] >= 0)
                                     : (m_i2[k][c] >= 0);
          if (pv0) m_act[k][c] = m_pend[k][c];
        end
        if (dv && !pv0)
          m_pend[k][c] = longint'(din[c*W +: W]);
      end
      if (tk && pv0) m_pv[k] = 1'b0;
      if (dv && !pv0) m_pv[k] = 1'b1;
      m_cnt[k] = tk ? 0 : m_cnt[k] + 1;
      m_tk[k]  = tk;
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_step(0, reset_n, d_a, dv_a);
    model_step(1, reset_n, d_b, dv_b);
    for (int c = 0; c < CH; c++) begin
      e.qa[c] = m_q[0][c];
      e.qb[c] = m_q[1][c];
    end
    e.ra = !m_pv[0];
    e.rb = !m_pv[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("q_a", q_a, e.qa);
    chk("rdy_a", rdy_a, e.ra);
    chk("q_b", q_b, e.qb);
    chk("rdy_b", rdy_b, e.rb);
  endtask

  initial begin
    int ones0;
    int ones1;
    int waited;
    int nt_chg;
    int t;
    logic found;
    logic [CH-1:0] q_prev;
    logic pat[6];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    d_a = {2{16'h8000}};
    d_b = {2{16'h8000}};
    cyc();
    cyc();
    chk("rst_q_a", q_a, 0);
    chk("rst_rdy_a", rdy_a, 1);
    chk("rst_q_b", q_b, 0);
    chk("rst_rdy_b", rdy_b, 1);

    reset_n = 1'b1;
    dv_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("mid_q", q_a[0], pat[i]);
    end

    dv_a = 1'b0;
    cyc();
    cyc();
    dv_a = 1'b1;
    cyc();
    chk("full_rdy", rdy_a, 0);
    reset_n = 1'b0;
    dv_a = 1'b0;
    cyc();
    chk("rst2_q", q_a, 0);
    chk("rst2_rdy", rdy_a, 1);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("restart_q", q_a[0], pat[i]);
    end

    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    d_a = {16'hFFFF, 16'h0000};
    dv_a = 1'b1;
    cyc();
    dv_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      cyc();
      if (q_a[1] === 1'b0) found = 1'b1;
    end
    chk("ffff_sync", found, 1);
    ones0 = 0;
    ones1 = 0;
    for (int i = 0; i < 65536; i++) begin
      cyc();
      ones0 += int'(q_a[0]);
      ones1 += int'(q_a[1]);
    end
    chk("ffff_ones", ones1, 65535);
    chk("zero_ones", ones0, 0);

    d_b = {16'hC000, 16'h4000};
    dv_b = 1'b1;
    cyc();
    dv_b = 1'b0;
    for (int i = 0; i < 256; i++) cyc();
    ones0 = 0;
    ones1 = 0;
    nt_chg = 0;
    t = 0;
    q_prev = q_b;
    while (t < 4096) begin
      cyc();
      if (m_tk[1]) begin
        t++;
        ones0 += int'(q_b[0]);
        ones1 += int'(q_b[1]);
      end else if (q_b !== q_prev) begin
        nt_chg++;
      end
      q_prev = q_b;
    end
    chk("o2_4000_in_1024pm2", ones0 >= 1022 && ones0 <= 1026, 1);
    chk("o2_c000_in_3072pm2", ones1 >= 3070 && ones1 <= 3074, 1);
    chk("o2_nontick_chg", nt_chg, 0);

    dv_b = 1'b1;
    d_b = {16'h1234, 16'h5678};
    cyc();
    chk("hs_first_rdy", rdy_b, 0);
    d_b = {16'h9ABC, 16'hDEF0};
    waited = 0;
    while (rdy_b !== 1'b1 && waited < 8) begin
      cyc();
      waited++;
    end
    chk("hs_wait_1to4", waited >= 1 && waited <= 4, 1);
    cyc();
    chk("hs_second_rdy", rdy_b, 0);
    dv_b = 1'b0;
    for (int i = 0; i < 16; i++) cyc();

    d_b = {16'hFFFE, 16'h0001};
    dv_b = 1'b1;
    cyc();
    dv_b = 1'b0;
    for (int i = 0; i < 2000; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sigma_delta_dac_nch.md
# sigma_delta_dac_nch

Multi-channel, parametrised sigma-delta DAC modulator; successor to the single-channel 16-bit first-order modulator. It accepts offset-binary PCM samples over a valid/ready handshake and emits one pulse-density bitstream per channel. Loop order (1 or 2), sample width, channel count and modulator update rate are parameters. It sits between the audio mixer/sample FIFO and the board-level output pins or RC filters.

## Interface
- WIDTH, 16, sample width per channel (8..24)
- CHANNELS, 2, number of independent modulators (1..8)
- ORDER, 1, loop order; 1 or 2, any other value is an elaboration error
- CE_DIV, 1, modulator updates once every CE_DIV clocks (1..65535)
- clk  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- d  in  CHANNELS*WIDTH  offset-binary samples; channel c at [c*WIDTH +: WIDTH]
- d_valid  in  1  all channels of d are valid this cycle
- d_ready  out  1  pending register empty; transfer on d_valid && d_ready
- q  out  CHANNELS  registered bitstream, bit c is channel c

## Operation
- H = 2^(WIDTH-1). Per channel: xs = d - H (signed, WIDTH+1 bits); fb = q ? +H : -H.
- Order 1: i1 <= sat(i1 + xs - fb); q <= (i1_new >= 0).
- Order 2: i1 <= sat(i1 + xs - fb); i2 <= sat(i2 + i1_new - fb); q <= (i2_new >= 0).
- i1 is WIDTH+3 bits signed, i2 is WIDTH+5 bits signed; sat() clamps to the register's min/max instead of wrapping.
- Output density = d / 2^WIDTH (d=0 -> all zero, d=2^WIDTH-1 -> one zero per 2^WIDTH ticks in order 1).
- Buffering: one pending register (all channels) plus one active register per channel. Handshake transfer loads pending and sets pend_valid. On a tick with pend_valid=1: active <= pending, pend_valid <= 0.
- d_ready = !pend_valid (combinational from a register). A transfer in a tick cycle with pend_valid=0 loads pending only; it reaches active on the next tick.
- Integrators always use the active register's value from before the tick.
- Tick generator: counter 0..CE_DIV-1; tick when count == CE_DIV-1, then wrap to 0. With CE_DIV=1, tick every cycle. Integrators and q change only on ticks.

## Timing
- Reset (reset_n=0 at a rising edge): i1=i2=0, q=0, active=H (midscale), pend_valid=0 (d_ready=1), tick counter=0, LFSR=seed. Reset during operation discards pending and active samples at the same edge.
- q is registered and updates at the tick edge. The first q update is on the first tick after release.
- Sample latency, order 1: handshake edge -> pending; next tick -> active; following tick -> first integrator step using it. q reflects the sample after 2 ticks with pend_valid=0, or 3 ticks if pend_valid was set.
- Full: while pend_valid=1, d_ready=0 and d is ignored. Empty: if no transfer occurs, active holds its value indefinitely.

## Configuration
- SDDAC_DITHER_EN defined: adds a 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1) that advances once per tick. Channel c adds dither (lfsr[2c] - lfsr[2c+1]) ∈ {-1,0,+1} LSB to xs.
- SDDAC_DITHER_EN undefined: no LFSR and no dither; behaviour is bit-exact to the equations above.

## Structure
- Package sddac_pkg: integrator width functions (WIDTH+3, WIDTH+5), saturation helpers, and the LFSR polynomial and seed constants.
- Sub-module sddac_channel: one modulator with active register, integrators and q. It is instantiated CHANNELS times under the shared tick, pending register, handshake and LFSR in the top level.

## Test plan
- ORDER=1, CE_DIV=1, no dither, d held at midscale (16'h8000) from reset -> q = 1,1,0,1,0,1,0… (50 % density).
- ORDER=1, d=16'h0000 -> q all zero. d=16'hFFFF -> over 65536 ticks, exactly 65535 ones.
- ORDER=2, d=16'h4000 -> ones count over 4096 ticks is 1024 ±2. Integrators never saturate at d=16'h0001 or 16'hFFFE.
- CE_DIV=4, handshake: two back-to-back valid samples -> second sees d_ready=0 until the next tick, where pend_valid clears. q changes only every 4th clock.
- CHANNELS=2, d = {16'hFFFF, 16'h0000} -> q[1] almost all 1s, q[0] all 0s. No cross-channel interaction.
- reset_n low for one cycle mid-stream with pend_valid=1 -> next edge shows q=0, d_ready=1. Midscale pattern restarts as 1,1,0,1…
